// File: rtl/gf2m_b409_pkg.sv
// Shared GF(2^409) definitions for the B-409 inverter and multiplier-side reducer.
// Field is reduced by the trinomial f(x) = x^409 + x^87 + 1.
package gf2m_b409_pkg;

    localparam int unsigned M     = 409;
    localparam int unsigned K     = 87;
    localparam int unsigned DEG_W = $clog2(M + 1);

    localparam logic [M:0] F = ((M + 1)'(1) << M) | ((M + 1)'(1) << K) | (M + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the highest set bit; 0 for an all-zero input.
    function automatic logic [DEG_W-1:0] poly_deg(input logic [M:0] p);
        logic [DEG_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i <= M; i++) begin
            if (p[i]) begin
                d = DEG_W'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/gf2m_inv_409_if.sv
// Operand/result handshake bundle for the GF(2^409) inverter.
// The slave side is the inverter; the master side feeds operands and drains results.
interface gf2m_inv_409_if;
    import gf2m_b409_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a_in;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] inv_out;
    logic         zero_err;

    modport master (
        output in_valid,
        input  in_ready,
        output a_in,
        input  out_valid,
        output out_ready,
        input  inv_out,
        input  zero_err
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a_in,
        output out_valid,
        input  out_ready,
        output inv_out,
        output zero_err
    );

endinterface

// File: rtl/gf2m_inv_409_div_x.sv
// Divide-by-x step of the binary Euclidean inverter: halves the remainder and
// halves its cofactor modulo f (adding f first when the cofactor is odd).
module gf2m_div_x
    import gf2m_b409_pkg::*;
(
    input  logic [M:0]   val,
    input  logic [M-1:0] g,
    output logic [M:0]   val_half,
    output logic [M-1:0] g_half
);

    logic [M:0] g_ext;
    logic [M:0] g_red;

    always_comb begin
        val_half = {1'b0, val[M:1]};
        g_ext    = {1'b0, g};
        g_red    = g[0] ? (g_ext ^ F) : g_ext;
        g_half   = g_red[M:1];
    end

endmodule

// File: rtl/gf2m_inv_409.sv
// Sequential GF(2^409) inverter (binary extended Euclidean), one reduction step
// per clock, with valid/ready handshakes on the operand and result sides.
module gf2m_inv_409
    import gf2m_b409_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    gf2m_inv_409_if.slave    bus
);

    localparam logic [M:0] U_ONE = (M + 1)'(1);

    state_t       state;
    logic [M:0]   u;
    logic [M:0]   v;
    logic [M-1:0] g1;
    logic [M-1:0] g2;

    logic [M:0]       u_half;
    logic [M:0]       v_half;
    logic [M-1:0]     g1_half;
    logic [M-1:0]     g2_half;
    logic [DEG_W-1:0] deg_u;
    logic [DEG_W-1:0] deg_v;

    gf2m_div_x u_div (
        .val      (u),
        .g        (g1),
        .val_half (u_half),
        .g_half   (g1_half)
    );

    gf2m_div_x v_div (
        .val      (v),
        .g        (g2),
        .val_half (v_half),
        .g_half   (g2_half)
    );

    always_comb begin
        deg_u = poly_deg(u);
        deg_v = poly_deg(v);
    end

    // Invariants g1*a == u and g2*a == v (mod f) hold after every step; the
    // rule order below keeps u and v coprime so neither collapses to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            u             <= '0;
            v             <= '0;
            g1            <= '0;
            g2            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.inv_out   <= '0;
            bus.zero_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (bus.a_in == '0) begin
                            bus.inv_out   <= '0;
                            bus.zero_err  <= 1'b1;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            u     <= {1'b0, bus.a_in};
                            v     <= F;
                            g1    <= M'(1);
                            g2    <= '0;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (u == U_ONE) begin
                        bus.inv_out   <= g1;
                        bus.zero_err  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (v == U_ONE) begin
                        bus.inv_out   <= g2;
                        bus.zero_err  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (!u[0]) begin
                        u  <= u_half;
                        g1 <= g1_half;
                    end else if (!v[0]) begin
                        v  <= v_half;
                        g2 <= g2_half;
                    end else if (deg_u > deg_v) begin
                        u  <= u ^ v;
                        g1 <= g1 ^ g2;
                    end else begin
                        v  <= v ^ u;
                        g2 <= g2 ^ g1;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gf2m_inv_409.md
Name: gf2m_inv_409

Overview:
- Sequential multiplicative inverter in GF(2^409), reduction trinomial f(x) = x^409 + x^87 + 1 (NIST B-409).
- It is the inverse-direction companion of the 409-bit overlap-free Karatsuba multiplier. A field divide a/b is formed as a·b⁻¹, so this block feeds the multiplier/reducer chain.
- Algorithm: binary extended Euclidean. One reduction step per clock, with a valid/ready handshake on input and output.

Parameters:
- M, 409, field degree; width of operands and result.
- K, 87, middle exponent of the trinomial reduction polynomial.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand a_in is presented.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- a_in  in  M  operand polynomial; bit i is the coefficient of x^i.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- inv_out  out  M  a⁻¹ mod f; zero when zero_err is set.
- zero_err  out  1  operand was 0, so no inverse exists; qualified by out_valid.

Behaviour:
- Registers:
  - u, v: M+1 bits each.
  - g1, g2: M bits each.
  - state ∈ {IDLE, RUN, DONE}.
  - Result register, and the zero_err flag.
- Reset (synchronous, rst=1 at the edge) from any state, including mid-RUN:
  - state=IDLE; in_ready=1; out_valid=0; inv_out=0; zero_err=0.
  - u, v, g1, g2 cleared.
  - An in-flight operation is discarded, with no output.
- IDLE:
  - in_ready=1.
  - On in_valid at the edge with a_in≠0: u={0,a_in}, v=F (the M+1-bit constant of f), g1=1, g2=0; go to RUN.
  - On in_valid at the edge with a_in=0: inv_out=0, zero_err=1; go straight to DONE. out_valid is high the next cycle.
- RUN: in_ready=0. Each edge applies exactly one action, first matching rule wins:
  1. u==1: inv_out=g1, zero_err=0, go to DONE.
  2. v==1: inv_out=g2, zero_err=0, go to DONE.
  3. u[0]==0: u=u>>1. g1 = (g1[0] ? ({0,g1}^F) : {0,g1}) >> 1, truncated to M bits.
  4. v[0]==0: same as rule 3, applied to v and g2.
  5. Otherwise (both odd):
     - deg(u) > deg(v): u^=v, g1^=g2.
     - else (including equal degree): v^=u, g2^=g1.
     - deg() is the index of the highest set bit, from a combinational priority encoder.
- Invariants, used as bench assertions: g1·a ≡ u and g2·a ≡ v (mod f); u and v are never both 0.
- Latency:
  - RUN always ends within 4·M+1 steps.
  - Total time from the acceptance edge to out_valid high is ≤ 4·M+2 cycles.
  - a_in=1 takes exactly 1 RUN edge.
- DONE:
  - out_valid=1; inv_out and zero_err held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE, so a new operand is accepted no earlier than the cycle after the output handshake.
- in_valid while busy is ignored; a_in is not sampled.
- Outputs are registered; there is no combinational path from any input to any output except none.

Decomposition:
- Shared package gf2m_b409_pkg holds:
  - M, K.
  - The M+1-bit constant F = (1<<M) | (1<<K) | 1.
  - The state enum typedef.
  - Reused by the multiplier-side reducer.
- Sub-module gf2m_div_x (combinational): takes an (M+1)-bit value and an M-bit g; returns value>>1 and the conditional (g^F)>>1. It is instantiated twice, for the u/g1 and v/g2 halving paths.
- Degree priority encoder: a function in the package.

Test Plan:
- a_in=1 → after 1 RUN cycle, out_valid=1, inv_out=1, zero_err=0. Acceptance-to-out_valid is 2 cycles.
- a_in=2 (x) → inv_out = x^408 + x^86, i.e. bits 408 and 86 set. Check x·inv ≡ 1.
- a_in=0 → out_valid the cycle after acceptance, zero_err=1, inv_out=0, no RUN cycles.
- Hold out_ready=0 for 20 cycles after out_valid:
  - inv_out and out_valid stay stable, in_ready=0, and a new in_valid is ignored.
  - Raise out_ready; the block returns to IDLE and then accepts the next operand.
- Assert rst for 1 cycle mid-RUN (for a_in = all-ones) → next cycle is IDLE with all outputs at reset values. The following a_in=1 gives inv_out=1.
- 2000 random nonzero a_in with random out_ready back-pressure → check a·inv_out mod f == 1 against a software model. Watchdog fails any run longer than 4·M+2 cycles.
